// File: rtl/integral_x_inverse.sv
// integral_x_inverse: recovers the upper bound num1 of the integral of x dx
// from the integral result (ComPart, Residue[0]) and the lower bound num2.
// Fixed 13-cycle start-to-done latency; err flags inexact or out-of-range roots.
module integral_x_inverse (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] ComPart,
  input  logic [1:0] Residue,
  input  logic [4:0] num2,
  output logic [4:0] num1,
  output logic       err,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    SQUARE,
    SUM,
    ROOT,
    CHECK
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  comp_q, comp_d;
  logic        res0_q, res0_d;
  logic [9:0]  mcand_q, mcand_d;
  logic [4:0]  mplier_q, mplier_d;
  logic [9:0]  acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] t_q, t_d;
  logic [4:0]  r_q, r_d;
  logic [4:0]  num1_q, num1_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic [4:0]  cand;
  logic [11:0] cand_sq;
  logic [11:0] root_sq;

  // Residue[1] carries no information for an integer integral of x dx.
  logic        unused_res1;
  assign unused_res1 = Residue[1];

  assign num1 = num1_q;
  assign err  = err_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

  // Root candidate for the current bit and the squares used by ROOT and CHECK.
  always_comb begin
    cand    = r_q | (5'd1 << cnt_q);
    cand_sq = 12'(cand) * 12'(cand);
    root_sq = 12'(r_q) * 12'(r_q);
  end

  // Next-state and datapath control; SQUARE and ROOT share cnt_q as iteration index.
  always_comb begin
    state_d  = state_q;
    comp_d   = comp_q;
    res0_d   = res0_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    t_d      = t_q;
    r_d      = r_q;
    num1_d   = num1_q;
    err_d    = err_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          comp_d   = ComPart;
          res0_d   = Residue[0];
          mcand_d  = {5'd0, num2};
          mplier_d = num2;
          acc_d    = '0;
          r_d      = '0;
          cnt_d    = '0;
          state_d  = SQUARE;
        end
      end
      SQUARE: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == 3'd4) begin
          state_d = SUM;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      SUM: begin
        t_d     = {1'b0, comp_q, 1'b0} + {11'd0, res0_q} + {2'd0, acc_q};
        cnt_d   = 3'd4;
        state_d = ROOT;
      end
      ROOT: begin
        if (cand_sq <= t_q) begin
          r_d = cand;
        end
        if (cnt_q == 3'd0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      CHECK: begin
        num1_d  = r_q;
        err_d   = (t_q > 12'd961) || (root_sq != t_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      comp_q   <= '0;
      res0_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      t_q      <= '0;
      r_q      <= '0;
      num1_q   <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      comp_q   <= comp_d;
      res0_q   <= res0_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      t_q      <= t_d;
      r_q      <= r_d;
      num1_q   <= num1_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_integral_x_inverse.sv
// Bench for integral_x_inverse: cycle-level reference model plus directed jobs.
module tb_integral_x_inverse;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] ComPart = '0;
  logic [1:0] Residue = '0;
  logic [4:0] num2 = '0;
  logic [4:0] num1;
  logic       err;
  logic       busy;
  logic       done;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int done_cnt = 0;

  // Reference model state: cycles left in the job, and expected outputs.
  int m_left = 0;
  int m_done = 0;
  int m_num1 = 0;
  int m_err  = 0;
  int p_num1 = 0;
  int p_err  = 0;

  integral_x_inverse dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ComPart (ComPart),
    .Residue (Residue),
    .num2    (num2),
    .num1    (num1),
    .err     (err),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Root by linear search over all 5-bit values.
  task automatic golden(input int c, input int r, input int n2,
                        output int n1, output int e);
    int t;
    t  = 2 * c + (r & 1) + n2 * n2;
    n1 = 0;
    for (int x = 0; x < 32; x++) if (x * x <= t) n1 = x;
    e = ((n1 * n1 != t) || (t > 961)) ? 1 : 0;
  endtask

  // Protocol model: accept in idle, result and done pulse 12 edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 0; m_num1 = 0; m_err = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1; m_num1 = p_num1; m_err = p_err;
        end
      end else if (start) begin
        golden(int'(ComPart), int'(Residue), int'(num2), p_num1, p_err);
        m_left = 12;
      end
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_num1", int'(num1), 0);
      check("rst_err",  int'(err),  0);
    end else begin
      check("mdl_busy", int'(busy), (m_left > 0) ? 1 : 0);
      check("mdl_done", int'(done), m_done);
      check("mdl_num1", int'(num1), m_num1);
      check("mdl_err",  int'(err),  m_err);
      if (done) done_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_ops(input int c, input int r, input int n2);
    ComPart = 10'(c); Residue = 2'(r); num2 = 5'(n2);
  endtask

  task automatic run_job(input int c, input int r, input int n2,
                         input int en1, input int eerr);
    int lat;
    int bcnt;
    int got;
    tick(1);
    set_ops(c, r, n2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    lat = 0; bcnt = 0; got = 0;
    for (int i = 1; i <= 30 && got == 0; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin got = 1; lat = i; end
    end
    check("job_done_seen", got, 1);
    if (got == 1) begin
      check("job_latency", lat, 13);
      check("job_busy_cycles", bcnt, 12);
      check("job_num1", int'(num1), en1);
      check("job_err", int'(err), eerr);
    end
  endtask

  initial begin
    int dc0;
    tick(3);
    check("reset_num1", int'(num1), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick(2);
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);

    // Directed jobs with hand-computed results.
    run_job(20, 0, 3, 7, 0);
    run_job(480, 1, 0, 31, 0);
    run_job(0, 0, 5, 5, 0);
    run_job(3, 0, 0, 2, 1);
    run_job(1023, 3, 31, 31, 1);
    run_job(1023, 1, 31, 31, 1);

    // Start pulses while busy are ignored; start held through done is accepted.
    tick(1);
    set_ops(20, 0, 3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    dc0 = done_cnt;
    tick(2);
    set_ops(480, 1, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    set_ops(3, 0, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    set_ops(0, 0, 5);
    start = 1'b1;
    tick(1);
    check("proto_done_a", int'(done), 1);
    check("proto_busy_a", int'(busy), 0);
    check("proto_num1_a", int'(num1), 7);
    check("proto_err_a", int'(err), 0);
    tick(1);
    start = 1'b0;
    check("proto_single_done", done_cnt - dc0, 1);
    check("proto_b2b_busy", int'(busy), 1);
    check("proto_b2b_done_low", int'(done), 0);
    tick(11);
    check("proto_done_d_early", int'(done), 0);
    tick(1);
    check("proto_done_d", int'(done), 1);
    check("proto_num1_d", int'(num1), 5);
    check("proto_err_d", int'(err), 0);
    check("proto_total_done", done_cnt - dc0, 1);

    // Asynchronous reset in the middle of a job.
    tick(1);
    set_ops(20, 0, 3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(8);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_num1", int'(num1), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    dc0 = done_cnt;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("midrst_no_done", done_cnt - dc0, 0);
    run_job(20, 0, 3, 7, 0);

    // Every exact pair n1 >= n2.
    for (int n1v = 0; n1v < 32; n1v++) begin
      for (int n2v = 0; n2v <= n1v; n2v++) begin
        int diff;
        diff = n1v * n1v - n2v * n2v;
        run_job(diff / 2, diff % 2, n2v, n1v, 0);
      end
    end

    tick(2);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
